phase_freq_est: RTL and testbench

- Sits directly downstream of the CORDIC phase stage and consumes its 16-bit phase samples and valid strobe.
- Computes the wrapped sample-to-sample phase difference, then averages it over non-overlapping windows of 2^LOG2_AVG differences.
- Emits one frequency-offset estimate per window, in phase units per sample, for the coarse CFO correction logic.

---
 rtl/phase_pkg.sv | 29 ++
 rtl/phase_freq_est_if.sv | 31 +++
 rtl/phase_wrap_diff.sv | 72 +++++++
 rtl/phase_freq_est.sv | 89 ++++++++
 tb/tb_phase_freq_est.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_pkg.sv
// Shared phase-domain types and helpers for the CORDIC phase consumers.
// The wrap helper works on plain ints so any phase width can reuse it.
package phase_pkg;

   localparam int PHASE_W_DEF   = 16;
   localparam int PHASE_PI_DEF  = 1608;
   localparam int PHASE_2PI_DEF = 3216;

   typedef logic signed [PHASE_W_DEF-1:0] phase_t;

   typedef enum logic {
      NOREF = 1'b0,
      ACCUM = 1'b1
   } ref_state_e;

   // Subtract, then fold back into [-pi, +pi] with at most one correction.
   // Exactly +pi / -pi are left untouched.
   function automatic int wrap_diff(input int cur, input int prev, input int pi);
      int d;
      d = cur - prev;
      if (d > pi) begin
         d = d - 2 * pi;
      end else if (d < -pi) begin
         d = d + 2 * pi;
      end
      return d;
   endfunction

endpackage

// File: rtl/phase_freq_est_if.sv
// Phase-sample input and frequency-estimate output bundle of phase_freq_est.
// No backpressure: the producer strobes ivalid, the consumer takes ovalid pulses.
interface phase_freq_est_if
   import phase_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF
);

   logic                      ivalid;
   logic signed [PHASE_W-1:0] phase;
   logic                      ovalid;
   logic signed [PHASE_W-1:0] freq;
   logic                      have_ref;

   modport master (
      output ivalid,
      output phase,
      input  ovalid,
      input  freq,
      input  have_ref
   );

   modport slave (
      input  ivalid,
      input  phase,
      output ovalid,
      output freq,
      output have_ref
   );

endinterface

// File: rtl/phase_wrap_diff.sv
// Holds the reference phase and registers the wrapped sample-to-sample difference.
// One cycle from sampled ivalid to d_vld_o; accepts a sample every clock, no backpressure.
module phase_wrap_diff
   import phase_pkg::*;
#(
   parameter int PHASE_W  = PHASE_W_DEF,
   parameter int PHASE_PI = PHASE_PI_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear_i,
   input  logic                      ivalid_i,
   input  logic signed [PHASE_W-1:0] phase_i,
   output logic signed [PHASE_W:0]   d_o,
   output logic                      d_vld_o,
   output logic                      have_ref_o
);

   typedef logic signed [PHASE_W:0] dw_t;

   ref_state_e                state_q, state_d;
   logic signed [PHASE_W-1:0] prev_q, prev_d;
   dw_t                       d_q, d_d;
   logic                      d_vld_q, d_vld_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= NOREF;
         prev_q  <= '0;
         d_q     <= '0;
         d_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         d_q     <= d_d;
         d_vld_q <= d_vld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      d_d     = d_q;
      d_vld_d = 1'b0;
      if (clear_i) begin
         // A sample arriving with clear becomes the fresh reference.
         state_d = ivalid_i ? ACCUM : NOREF;
         if (ivalid_i) begin
            prev_d = phase_i;
         end
      end else if (ivalid_i) begin
         prev_d = phase_i;
         case (state_q)
            NOREF: begin
               state_d = ACCUM;
            end
            ACCUM: begin
               d_d     = dw_t'(wrap_diff(int'(phase_i), int'(prev_q), PHASE_PI));
               d_vld_d = 1'b1;
            end
            default: begin
               state_d = NOREF;
            end
         endcase
      end
   end

   assign d_o        = d_q;
   assign d_vld_o    = d_vld_q;
   assign have_ref_o = (state_q == ACCUM);

endmodule

// File: rtl/phase_freq_est.sv
// Averages wrapped phase steps over windows of 2^LOG2_AVG and emits one CFO estimate per window.
// ovalid fires 2 cycles after the window's last sample; 1 sample/clock, no backpressure.
module phase_freq_est
   import phase_pkg::*;
#(
   parameter int PHASE_W  = PHASE_W_DEF,
   parameter int PHASE_PI = PHASE_PI_DEF,
   parameter int LOG2_AVG = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   phase_freq_est_if.slave  pif
);

   localparam int AW = PHASE_W + LOG2_AVG;

   logic signed [PHASE_W:0]   d;
   logic                      d_vld;
   logic                      have_ref;

   logic signed [AW-1:0]      acc_q, acc_d;
   logic [LOG2_AVG-1:0]       cnt_q, cnt_d;
   logic signed [PHASE_W-1:0] freq_q, freq_d;
   logic                      ovalid_q, ovalid_d;

   logic signed [AW-1:0]      d_ext;
   logic signed [AW-1:0]      sum;

   phase_wrap_diff #(
      .PHASE_W  (PHASE_W),
      .PHASE_PI (PHASE_PI)
   ) u_wrap_diff (
      .clock      (clock),
      .reset      (reset),
      .clear_i    (clear),
      .ivalid_i   (pif.ivalid),
      .phase_i    (pif.phase),
      .d_o        (d),
      .d_vld_o    (d_vld),
      .have_ref_o (have_ref)
   );

   assign d_ext = AW'(d);
   assign sum   = acc_q + d_ext;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         freq_q   <= '0;
         ovalid_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         freq_q   <= freq_d;
         ovalid_q <= ovalid_d;
      end
   end

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      freq_d   = freq_q;
      ovalid_d = 1'b0;
      if (d_vld) begin
         if (&cnt_q) begin
            // Arithmetic shift floors the mean; |mean| <= pi always fits.
            freq_d   = PHASE_W'(sum >>> LOG2_AVG);
            ovalid_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
      // A window completing on the clear edge still reports; the partial window is dropped.
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   assign pif.ovalid   = ovalid_q;
   assign pif.freq     = freq_q;
   assign pif.have_ref = have_ref;

endmodule

// File: tb/tb_phase_freq_est.sv
// Directed bench for phase_freq_est: window-level mean model plus literal spot checks.
module tb_phase_freq_est;
   import phase_pkg::*;

   localparam int W  = 16;
   localparam int PI = 1608;
   localparam int N  = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;

   phase_freq_est_if #(.PHASE_W(W)) pif ();

   phase_freq_est #(
      .PHASE_W  (W),
      .PHASE_PI (PI),
      .LOG2_AVG (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .pif   (pif.slave)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int ov_count = 0;
   time ov_time = 0;

   // Model state: reference, pending diffs of the open window, scheduled outputs.
   int m_have_ref = 0;
   int m_prev = 0;
   int m_diffs[$];
   int ev_step[$];
   int ev_val[$];
   int step = 0;
   int exp_ovalid = 0;
   int exp_freq = 0;
   int exp_have_ref = 0;

   function automatic int model_wrap(input int d);
      if (d > PI) return d - 2 * PI;
      if (d < -PI) return d + 2 * PI;
      return d;
   endfunction

   function automatic int floor_mean(input int s);
      int q;
      q = s / N;
      if (s < 0 && q * N != s) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare at negedge against the model, then advance the model with the inputs
   // that the next rising edge will capture.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            m_have_ref = 0;
            m_prev = 0;
            m_diffs.delete();
            ev_step.delete();
            ev_val.delete();
            exp_ovalid = 0;
            exp_freq = 0;
            exp_have_ref = 0;
         end
         chk("cyc_ovalid", int'(pif.ovalid), exp_ovalid);
         chk("cyc_freq", int'(pif.freq), exp_freq);
         chk("cyc_have_ref", int'(pif.have_ref), exp_have_ref);
         if (pif.ovalid) begin
            ov_count++;
            ov_time = $time;
         end
         if (reset) begin
            step++;
            exp_ovalid = 0;
            if (ev_step.size() > 0 && ev_step[0] == step) begin
               exp_ovalid = 1;
               exp_freq = ev_val[0];
               void'(ev_step.pop_front());
               void'(ev_val.pop_front());
            end
            if (clear) begin
               m_diffs.delete();
               m_have_ref = int'(pif.ivalid);
               if (pif.ivalid) m_prev = int'(pif.phase);
            end else if (pif.ivalid) begin
               if (m_have_ref == 0) begin
                  m_have_ref = 1;
               end else begin
                  m_diffs.push_back(model_wrap(int'(pif.phase) - m_prev));
                  if (m_diffs.size() == N) begin
                     int s;
                     s = 0;
                     foreach (m_diffs[i]) s += m_diffs[i];
                     ev_step.push_back(step + 1);
                     ev_val.push_back(floor_mean(s));
                     m_diffs.delete();
                  end
               end
               m_prev = int'(pif.phase);
            end
            exp_have_ref = m_have_ref;
         end
      end
   end

   task automatic send(input logic v, input int ph, input logic c);
      pif.ivalid = v;
      pif.phase  = phase_t'(ph);
      clear      = c;
      @(posedge clock);
      #1;
      pif.ivalid = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 0, 1'b0);
   endtask

   task automatic restart();
      send(1'b0, 0, 1'b1);
      idle(1);
   endtask

   initial begin
      int n0;
      int p;
      time t9;

      pif.ivalid = 1'b0;
      pif.phase  = '0;
      #2;
      chk("rst_ovalid", int'(pif.ovalid), 0);
      chk("rst_freq", int'(pif.freq), 0);
      chk("rst_have_ref", int'(pif.have_ref), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      idle(2);

      // Constant phase: one estimate of 0, two cycles after the 9th sample.
      n0 = ov_count;
      send(1'b1, 100, 1'b0);
      chk("const_have_ref", int'(pif.have_ref), 1);
      for (int i = 1; i < 9; i++) send(1'b1, 100, 1'b0);
      t9 = $time;
      idle(4);
      chk("const_ovcnt", ov_count - n0, 1);
      chk("const_freq", int'(pif.freq), 0);
      chk("const_latency", int'(ov_time - t9), 14);

      // Ramp of 50, then a contiguous second window.
      restart();
      n0 = ov_count;
      for (int i = 0; i <= 8; i++) send(1'b1, 50 * i, 1'b0);
      idle(3);
      chk("ramp_ovcnt1", ov_count - n0, 1);
      chk("ramp_freq1", int'(pif.freq), 50);
      for (int i = 9; i <= 16; i++) send(1'b1, 50 * i, 1'b0);
      idle(3);
      chk("ramp_ovcnt2", ov_count - n0, 2);
      chk("ramp_freq2", int'(pif.freq), 50);

      // Steps of +158 crossing +pi, then -158 crossing -pi.
      restart();
      p = 1342;
      for (int i = 0; i < 9; i++) begin
         send(1'b1, p, 1'b0);
         p = p + 158;
         if (p > PI) p = p - 2 * PI;
      end
      idle(3);
      chk("wrap_pos_freq", int'(pif.freq), 158);
      restart();
      p = -1342;
      for (int i = 0; i < 9; i++) begin
         send(1'b1, p, 1'b0);
         p = p - 158;
         if (p < -PI) p = p + 2 * PI;
      end
      idle(3);
      chk("wrap_neg_freq", int'(pif.freq), -158);

      // Floor rounding of small means.
      restart();
      for (int i = 0; i < 8; i++) send(1'b1, 0, 1'b0);
      send(1'b1, -1, 1'b0);
      idle(3);
      chk("round_neg", int'(pif.freq), -1);
      restart();
      for (int i = 0; i < 8; i++) send(1'b1, 0, 1'b0);
      send(1'b1, 1, 1'b0);
      idle(3);
      chk("round_pos", int'(pif.freq), 0);

      // A step of exactly +pi is not wrapped: mean 1608/8 = 201.
      restart();
      send(1'b1, 0, 1'b0);
      for (int i = 0; i < 8; i++) send(1'b1, 1608, 1'b0);
      idle(3);
      chk("exact_pi", int'(pif.freq), 201);

      // Clear after 4 diffs with a same-cycle sample as new reference.
      restart();
      n0 = ov_count;
      for (int i = 0; i < 5; i++) send(1'b1, 300 * i, 1'b0);
      send(1'b1, 0, 1'b1);
      chk("clr_have_ref", int'(pif.have_ref), 1);
      for (int i = 1; i < 8; i++) send(1'b1, 10 * i, 1'b0);
      idle(3);
      chk("clr_no_ov", ov_count - n0, 0);
      chk("clr_freq_held", int'(pif.freq), 201);
      send(1'b1, 80, 1'b0);
      idle(3);
      chk("clr_ovcnt", ov_count - n0, 1);
      chk("clr_freq", int'(pif.freq), 10);

      // Reset mid-window abandons everything.
      restart();
      for (int i = 0; i < 5; i++) send(1'b1, 7, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ovalid", int'(pif.ovalid), 0);
      chk("mid_rst_freq", int'(pif.freq), 0);
      chk("mid_rst_have_ref", int'(pif.have_ref), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      n0 = ov_count;
      for (int i = 0; i < 8; i++) send(1'b1, 500, 1'b0);
      idle(3);
      chk("post_rst_no_ov", ov_count - n0, 0);
      send(1'b1, 500, 1'b0);
      idle(3);
      chk("post_rst_ovcnt", ov_count - n0, 1);
      chk("post_rst_freq", int'(pif.freq), 0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
